// File: rtl/cim_pkg.sv
// Shared defaults and FSM encoding for the activation serializer datapath.
package cim_pkg;
    localparam int CIM_OUT_PRECISION = 6;
    localparam int CIM_DIM           = 3;
    localparam int CIM_Q_PRECISION   = 4;
    localparam int CIM_SHIFT         = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;
endpackage

// File: rtl/act_requant.sv
// One-lane requantizer: round-half-up right shift, saturated to Q_PRECISION bits.
module act_requant #(
    parameter int OUT_PRECISION = 6,
    parameter int Q_PRECISION   = 4,
    parameter int SHIFT         = 2
) (
    input  logic [OUT_PRECISION-1:0] x_i,
    output logic [Q_PRECISION-1:0]   q_o
);
    // Wide enough for the rounded sum and for the saturation constant.
    localparam int W = (OUT_PRECISION + 1 > Q_PRECISION + 1) ? OUT_PRECISION + 1 : Q_PRECISION + 1;
    localparam logic [W-1:0] RND  = W'((1 << SHIFT) >> 1);
    localparam logic [W-1:0] MAXQ = W'((1 << Q_PRECISION) - 1);

    logic [W-1:0] sum;
    logic [W-1:0] shr;

    assign sum = W'(x_i) + RND;
    assign shr = sum >> SHIFT;
    assign q_o = (shr > MAXQ) ? MAXQ[Q_PRECISION-1:0] : shr[Q_PRECISION-1:0];
endmodule

// File: rtl/act_serializer.sv
// Requantizes captured aggregated words and streams their lanes out one per
// accepted transfer, with a one-deep pending buffer behind the active word.
module act_serializer
    import cim_pkg::*;
#(
    parameter int OUT_PRECISION = CIM_OUT_PRECISION,
    parameter int DIM           = CIM_DIM,
    parameter int Q_PRECISION   = CIM_Q_PRECISION,
    parameter int SHIFT         = CIM_SHIFT,
    parameter int LW            = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         capture,
    input  logic [OUT_PRECISION*DIM-1:0] agg_in,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [Q_PRECISION-1:0]       out_data,
    output logic [LW-1:0]                out_lane,
    output logic                         busy,
    output logic                         overflow
);
    localparam logic [LW-1:0] LAST_LANE = LW'(DIM - 1);

    logic [DIM-1:0][Q_PRECISION-1:0] req_w;
    logic [DIM-1:0][Q_PRECISION-1:0] act_q, act_d;
    logic [DIM-1:0][Q_PRECISION-1:0] pend_q, pend_d;
    logic                            pend_full_q, pend_full_d;
    logic [LW-1:0]                   lane_q, lane_d;
    logic                            ovf_q, ovf_d;
    ser_state_e                      state_q, state_d;
    logic                            fire, last;

    for (genvar k = 0; k < DIM; k++) begin : g_lane
        act_requant #(
            .OUT_PRECISION(OUT_PRECISION),
            .Q_PRECISION  (Q_PRECISION),
            .SHIFT        (SHIFT)
        ) u_requant (
            .x_i(agg_in[k*OUT_PRECISION +: OUT_PRECISION]),
            .q_o(req_w[k])
        );
    end

    assign fire = (state_q == SEND) && out_ready;
    assign last = fire && (lane_q == LAST_LANE);

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        lane_d      = lane_q;
        ovf_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    act_d   = req_w;
                    lane_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last) begin
                    lane_d = '0;
                    if (pend_full_q) begin
                        // Pending slot frees as it moves up, so a same-cycle capture refills it.
                        act_d = pend_q;
                        if (capture) pend_d = req_w;
                        else         pend_full_d = 1'b0;
                    end else if (capture) begin
                        act_d = req_w;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (fire) lane_d = LW'(lane_q + 1'b1);
                    if (capture) begin
                        if (!pend_full_q) begin
                            pend_d      = req_w;
                            pend_full_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            lane_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            lane_q      <= lane_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_data  = act_q[lane_q];
    assign out_lane  = lane_q;
    assign busy      = (state_q == SEND) || pend_full_q;
    assign overflow  = ovf_q;
endmodule
